// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/branch sequencer.
//   state_t : sequencer state encoding
//   J_LT/J_EQ/J_GT : jump-condition bit positions inside a C-instruction
//   C_BIT : bit that marks a C-instruction (0 = A-instruction)
package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   localparam int J_LT  = 2;
   localparam int J_EQ  = 1;
   localparam int J_GT  = 0;
   localparam int C_BIT = 15;

endpackage

// File: rtl/fetch_sequencer_jump_cond.sv
// Hack jump-condition decode, purely combinational.
// Ports:
//   c_instr : 1 = C-instruction; A-instructions never jump
//   j_lt    : jump if ALU result < 0
//   j_eq    : jump if ALU result == 0
//   j_gt    : jump if ALU result > 0
//   zr, ng  : ALU zero / negative flags
//   jmp     : jump taken
module jump_cond (
   input  logic c_instr,
   input  logic j_lt,
   input  logic j_eq,
   input  logic j_gt,
   input  logic zr,
   input  logic ng,
   output logic jmp
);

   // "greater than" is neither negative nor zero
   assign jmp = c_instr & ((j_lt & ng) | (j_eq & zr) | (j_gt & ~ng & ~zr));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/branch sequencer wrapped around the program counter.
// Fetches the word at pc from the instruction ROM, holds it in the
// instruction register for one retire cycle, then steers the counter to
// either load the A register (jump) or increment.
//
// Ports:
//   clk, res      : clock, synchronous active-low reset
//   pc, a_in      : counter value, jump target
//   zr, ng        : ALU flags, sampled during EXEC
//   exec_hold     : datapath stall, keeps EXEC
//   rom_data/valid: ROM response
//   rom_req/addr  : ROM request (addr is pc)
//   instr         : instruction register
//   instr_valid   : instr executes this cycle
//   pc_res/load/inc/in : counter controls
//   icount        : retired-instruction count (wraps)
//   err           : sticky ROM-timeout flag
//
// state | meaning
// ------+---------------------------------------------------------
// BOOT  | one cycle after reset; clears the counter
// FETCH | rom_req high, waiting for rom_valid; wait timer running
// EXEC  | instr issued; retire steers counter unless exec_hold
module fetch_sequencer #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             res,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] a_in,
   input  logic             zr,
   input  logic             ng,
   input  logic             exec_hold,
   input  logic [WIDTH-1:0] rom_data,
   input  logic             rom_valid,
   output logic             rom_req,
   output logic [WIDTH-1:0] rom_addr,
   output logic [WIDTH-1:0] instr,
   output logic             instr_valid,
   output logic             pc_res,
   output logic             pc_load,
   output logic             pc_inc,
   output logic [WIDTH-1:0] pc_in,
   output logic [WIDTH-1:0] icount,
   output logic             err
);

   import fetch_sequencer_pkg::*;

   // wait timer counts down from TIMEOUT; terminal count flags the error
   localparam int WW = $clog2(TIMEOUT + 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] instr_q;
   logic [WIDTH-1:0] icount_q;
   logic [WIDTH-1:0] icount_inc;
   logic [WW-1:0]    wcnt;
   logic             err_q;
   logic             jmp;

   assign rom_addr   = pc;
   assign pc_in      = a_in;
   assign instr      = instr_q;
   assign icount     = icount_q;
   assign err        = err_q;
   assign icount_inc = icount_q + WIDTH'(1);

   jump_cond u_jump (
      .c_instr (instr_q[C_BIT]),
      .j_lt    (instr_q[J_LT]),
      .j_eq    (instr_q[J_EQ]),
      .j_gt    (instr_q[J_GT]),
      .zr      (zr),
      .ng      (ng),
      .jmp     (jmp)
   );

   always_comb begin
      state_nxt   = state;
      pc_res      = 1'b0;
      rom_req     = 1'b0;
      instr_valid = 1'b0;
      pc_load     = 1'b0;
      pc_inc      = 1'b0;
      case (state)
         BOOT: begin
            pc_res    = 1'b1;
            state_nxt = FETCH;
         end
         FETCH: begin
            rom_req = 1'b1;
            if (rom_valid) state_nxt = EXEC;
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (!exec_hold) begin
               pc_load   = jmp;
               pc_inc    = ~jmp;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         state    <= BOOT;
         instr_q  <= '0;
         icount_q <= '0;
         err_q    <= 1'b0;
         wcnt     <= WW'(TIMEOUT);
      end else begin
         state <= state_nxt;
         if (state == FETCH) begin
            if (rom_valid) begin
               instr_q <= rom_data;
               wcnt    <= WW'(TIMEOUT);
            end else if (wcnt != '0) begin
               wcnt <= wcnt - WW'(1);
               // last decrement means TIMEOUT idle cycles have elapsed
               if (wcnt == WW'(1)) err_q <= 1'b1;
            end
         end
         if (state == EXEC && !exec_hold) icount_q <= icount_inc;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   localparam int W  = 16;
   localparam int TO = 3;

   logic          clk = 1'b0;
   logic          res;
   logic [W-1:0]  pc, a_in, rom_data;
   logic          zr, ng, exec_hold, rom_valid;
   logic          rom_req, instr_valid, pc_res, pc_load, pc_inc, err;
   logic [W-1:0]  rom_addr, instr, pc_in, icount;

   int checks = 0;
   int errors = 0;

   // reference model: architectural view only
   logic [W-1:0]  m_pc, m_instr, m_icount;
   logic          m_err;
   int            m_wait;

   fetch_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .res(res), .pc(pc), .a_in(a_in), .zr(zr), .ng(ng),
      .exec_hold(exec_hold), .rom_data(rom_data), .rom_valid(rom_valid),
      .rom_req(rom_req), .rom_addr(rom_addr), .instr(instr),
      .instr_valid(instr_valid), .pc_res(pc_res), .pc_load(pc_load),
      .pc_inc(pc_inc), .pc_in(pc_in), .icount(icount), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed time %0t expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n, input logic hold_val);
      res       = 1'b0;
      exec_hold = hold_val;
      rom_valid = 1'b1;
      rom_data  = 16'($urandom);
      pc        = 16'($urandom);
      for (int i = 0; i < n; i++) begin
         tick();
         #1;
         chk1("rst_pc_res", pc_res, 1'b1);
         chk1("rst_rom_req", rom_req, 1'b0);
         chk1("rst_instr_valid", instr_valid, 1'b0);
         chkw("rst_instr", instr, 16'h0000);
         chkw("rst_icount", icount, 16'h0000);
         chk1("rst_err", err, 1'b0);
         chkw("rst_rom_addr", rom_addr, pc);
      end
      res       = 1'b1;
      exec_hold = 1'b0;
      rom_valid = 1'b0;
      #1;
      chk1("boot_pc_res", pc_res, 1'b1);
      chk1("boot_rom_req", rom_req, 1'b0);
      chk1("boot_pc_load", pc_load, 1'b0);
      chk1("boot_pc_inc", pc_inc, 1'b0);
      tick();
      m_pc = '0; m_instr = '0; m_icount = '0; m_err = 1'b0; m_wait = 0;
      pc = m_pc;
      #1;
      chk1("fetch1_pc_res", pc_res, 1'b0);
      chk1("fetch1_rom_req", rom_req, 1'b1);
      chkw("fetch1_addr", rom_addr, 16'h0000);
      chkw("fetch1_icount", icount, 16'h0000);
   endtask

   // one complete instruction: ROM wait states, EXEC holds, retire
   task automatic do_instr(input logic [W-1:0] word, input int delay, input int hold,
                           input logic [W-1:0] alu, input logic [W-1:0] a, input bit preload);
      bit take;
      for (int d = 0; d < delay; d++) begin
         rom_valid = 1'b0;
         rom_data  = 16'($urandom);
         zr = 1'($urandom); ng = 1'($urandom);
         #1;
         chk1("wait_rom_req", rom_req, 1'b1);
         chkw("wait_addr", rom_addr, m_pc);
         chkw("wait_instr", instr, m_instr);
         chk1("wait_pc_load", pc_load, 1'b0);
         chk1("wait_pc_inc", pc_inc, 1'b0);
         chk1("wait_instr_valid", instr_valid, 1'b0);
         tick();
         m_wait++;
         if (m_wait >= TO) m_err = 1'b1;
         chk1("wait_err", err, m_err);
      end
      rom_valid = 1'b1;
      rom_data  = word;
      #1;
      chk1("fetch_rom_req", rom_req, 1'b1);
      chkw("fetch_addr", rom_addr, m_pc);
      tick();
      m_instr = word;
      m_wait  = 0;

      // flags derived from a signed ALU result
      zr   = (alu == '0);
      ng   = ($signed(alu) < 0);
      a_in = a;
      take = word[15] && ((word[2] && $signed(alu) < 0) ||
                          (word[1] && alu == '0) ||
                          (word[0] && $signed(alu) > 0));
      for (int h = 0; h < hold; h++) begin
         exec_hold = 1'b1;
         rom_valid = 1'($urandom);
         rom_data  = 16'($urandom);
         #1;
         chk1("hold_instr_valid", instr_valid, 1'b1);
         chkw("hold_instr", instr, m_instr);
         chk1("hold_pc_load", pc_load, 1'b0);
         chk1("hold_pc_inc", pc_inc, 1'b0);
         chkw("hold_icount", icount, m_icount);
         tick();
      end
      exec_hold = 1'b0;
      rom_valid = 1'($urandom);
      rom_data  = 16'($urandom);
      #1;
      chk1("exec_instr_valid", instr_valid, 1'b1);
      chkw("exec_instr", instr, m_instr);
      chk1("exec_pc_load", pc_load, take);
      chk1("exec_pc_inc", pc_inc, !take);
      chkw("exec_pc_in", pc_in, a);
      chk1("exec_rom_req", rom_req, 1'b0);
      if (preload) force dut.icount_inc = 16'hFFFF;
      tick();
      if (preload) begin
         release dut.icount_inc;
         m_icount = 16'hFFFF;
      end else begin
         m_icount = m_icount + 16'd1;
      end
      m_pc = take ? a : 16'(m_pc + 16'd1);
      pc = m_pc;
      rom_valid = 1'b0;
      #1;
      chkw("retire_icount", icount, m_icount);
      chk1("retire_rom_req", rom_req, 1'b1);
      chk1("retire_instr_valid", instr_valid, 1'b0);
      chkw("retire_instr", instr, m_instr);
      chkw("retire_addr", rom_addr, m_pc);
      chk1("retire_err", err, m_err);
   endtask

   initial begin
      logic [W-1:0] w, alu;
      res = 1'b0; pc = '0; a_in = '0; zr = 1'b0; ng = 1'b0;
      exec_hold = 1'b0; rom_data = '0; rom_valid = 1'b0;

      do_reset(3, 1'b0);

      // sequential A-instruction, zero-wait ROM
      do_instr(16'h0005, 0, 0, 16'h0003, 16'h1234, 1'b0);
      chkw("seq_addr_pc1", rom_addr, 16'h0001);

      // JEQ taken on zero, then not taken on negative
      do_instr(16'hE302, 0, 0, 16'h0000, 16'h0040, 1'b0);
      chkw("jeq_target", rom_addr, 16'h0040);
      do_instr(16'hE302, 0, 0, 16'h8001, 16'h0040, 1'b0);
      chkw("jeq_notaken", rom_addr, 16'h0041);

      // four wait states; TIMEOUT=3 trips err, which must stay set
      do_instr(16'hE307, 4, 0, 16'h0010, 16'h0100, 1'b0);
      chk1("err_sticky", err, 1'b1);

      // three-cycle stall, then wrap of the retire counter
      do_instr(16'hE301, 0, 3, 16'h0001, 16'h0200, 1'b0);
      do_instr(16'h0007, 1, 1, 16'h0000, 16'h0300, 1'b1);
      chkw("icount_preload", icount, 16'hFFFF);
      do_instr(16'hE304, 0, 0, 16'hFFFF, 16'h0400, 1'b0);
      chkw("icount_wrap", icount, 16'h0000);

      // randomized instructions
      for (int i = 0; i < 24; i++) begin
         w = 16'($urandom);
         case ($urandom_range(0, 2))
            0: alu = 16'h0000;
            1: alu = 16'($urandom_range(1, 32767));
            default: alu = 16'h8000 | 16'($urandom);
         endcase
         do_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), alu, 16'($urandom), 1'b0);
      end

      // reset while waiting on the ROM
      rom_valid = 1'b0;
      tick();
      tick();
      do_reset(1, 1'b0);

      // reset during an EXEC hold, coinciding with a retire attempt
      do_instr(16'h0011, 0, 0, 16'h0001, 16'h0050, 1'b0);
      do_instr(16'hE302, 0, 0, 16'h0000, 16'h0060, 1'b0);
      chkw("pre_rst_icount", icount, 16'h0002);
      rom_valid = 1'b1;
      rom_data  = 16'hE307;
      tick();
      rom_valid = 1'b0;
      exec_hold = 1'b1;
      tick();
      tick();
      #1;
      chk1("held_instr_valid", instr_valid, 1'b1);
      chkw("held_icount", icount, 16'h0002);
      do_reset(1, 1'b0);
      do_instr(16'h0022, 0, 0, 16'h0005, 16'h0070, 1'b0);
      chkw("post_rst_icount", icount, 16'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
